// File: rtl/mul_err_stats.sv
// Error-statistics stage for the approximate 16x16 signed multiplier: shifts the
// approximate and exact products, then accumulates error metrics over N samples.
module mul_err_stats #(
   parameter int OUT_WIDTH   = 32,
   parameter int SHIFT_WIDTH = 8,
   parameter int CNT_WIDTH   = 16,
   parameter int ACC_WIDTH   = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] num_samples,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [OUT_WIDTH-1:0] appr_in,
   input  logic [OUT_WIDTH-1:0] exact_in,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] sample_cnt,
   output logic [CNT_WIDTH-1:0] same_cnt,
   output logic [ACC_WIDTH-1:0] err_sum,
   output logic [ACC_WIDTH-1:0] err_sq_sum,
   output logic [ACC_WIDTH-1:0] abs_sum,
   output logic [OUT_WIDTH:0]   max_abs_err,
   output logic [1:0]           dbg_state
);

   localparam int EW    = OUT_WIDTH + 1;
   localparam int SQ_W  = 2 * EW;
   localparam int SUM_W = ((SQ_W > ACC_WIDTH) ? SQ_W : ACC_WIDTH) + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                r_state, w_next;
   logic [CNT_WIDTH-1:0]  r_n, r_sample_cnt, r_same_cnt;
   logic [ACC_WIDTH-1:0]  r_err_sum, r_err_sq_sum, r_abs_sum;
   logic [EW-1:0]         r_max_abs_err;
   logic                  r_done, r_v1, r_v2;
   logic [OUT_WIDTH-1:0]  r_e;
   logic [EW-1:0]         r_err;

   logic signed [OUT_WIDTH-1:0] w_a, w_e;
   logic [EW-1:0]         w_err, w_abs_err, w_e_ext, w_abs_e;
   logic [SQ_W-1:0]       w_sq;
   logic [SUM_W-1:0]      w_sq_full;
   logic                  w_sq_sat, w_accept, w_clear, w_enter_done;

   // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
   // in_ready depends only on registered state, never on in_valid.
   assign in_ready    = (r_state == S_RUN) && (r_sample_cnt < r_n);
   assign w_accept    = in_valid && in_ready;
   assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign done        = r_done;
   assign sample_cnt  = r_sample_cnt;
   assign same_cnt    = r_same_cnt;
   assign err_sum     = r_err_sum;
   assign err_sq_sum  = r_err_sq_sum;
   assign abs_sum     = r_abs_sum;
   assign max_abs_err = r_max_abs_err;
   assign dbg_state   = r_state;

   assign w_a   = $signed(appr_in) >>> SHIFT_WIDTH;
   assign w_e   = $signed(exact_in) >>> SHIFT_WIDTH;
   assign w_err = {w_a[OUT_WIDTH-1], w_a} - {w_e[OUT_WIDTH-1], w_e};

   // Stage-2 operands come from the registered stage-1 values.
   assign w_abs_err = r_err[EW-1] ? -r_err : r_err;
   assign w_e_ext   = {r_e[OUT_WIDTH-1], r_e};
   assign w_abs_e   = w_e_ext[EW-1] ? -w_e_ext : w_e_ext;
   assign w_sq      = {{EW{1'b0}}, w_abs_err} * {{EW{1'b0}}, w_abs_err};
   assign w_sq_full = {{(SUM_W-SQ_W){1'b0}}, w_sq} + {{(SUM_W-ACC_WIDTH){1'b0}}, r_err_sq_sum};
   assign w_sq_sat  = |w_sq_full[SUM_W-1:ACC_WIDTH];

   always_comb begin
      w_next       = r_state;
      w_clear      = 1'b0;
      w_enter_done = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_clear = 1'b1;
               if (num_samples == '0) begin
                  w_next       = S_DONE;
                  w_enter_done = 1'b1;
               end else begin
                  w_next = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (w_accept && ((r_sample_cnt + CNT_ONE) == r_n)) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            // Leave only once the last sample has passed through both stages.
            if (!r_v1 && !r_v2) begin
               w_next       = S_DONE;
               w_enter_done = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_n           <= '0;
         r_sample_cnt  <= '0;
         r_same_cnt    <= '0;
         r_err_sum     <= '0;
         r_err_sq_sum  <= '0;
         r_abs_sum     <= '0;
         r_max_abs_err <= '0;
         r_done        <= 1'b0;
         r_v1          <= 1'b0;
         r_v2          <= 1'b0;
         r_e           <= '0;
         r_err         <= '0;
      end else begin
         r_state <= w_next;
         r_done  <= w_enter_done;
         r_v1    <= w_accept;
         r_v2    <= r_v1;
         if (w_accept) begin
            r_e          <= w_e;
            r_err        <= w_err;
            r_sample_cnt <= r_sample_cnt + CNT_ONE;
         end
         if (w_clear) begin
            r_n           <= num_samples;
            r_sample_cnt  <= '0;
            r_same_cnt    <= '0;
            r_err_sum     <= '0;
            r_err_sq_sum  <= '0;
            r_abs_sum     <= '0;
            r_max_abs_err <= '0;
         end else if (r_v1) begin
            r_err_sum    <= r_err_sum + {{(ACC_WIDTH-EW){r_err[EW-1]}}, r_err};
            r_err_sq_sum <= w_sq_sat ? {ACC_WIDTH{1'b1}} : w_sq_full[ACC_WIDTH-1:0];
            r_abs_sum    <= r_abs_sum + {{(ACC_WIDTH-EW){1'b0}}, w_abs_e};
            if (r_err == '0) r_same_cnt <= r_same_cnt + CNT_ONE;
            if (w_abs_err > r_max_abs_err) r_max_abs_err <= w_abs_err;
         end
      end
   end

endmodule

// File: tb/tb_mul_err_stats.sv
// Directed bench for mul_err_stats: runs push expected statistics into a queue,
// a monitor pops and compares them on every done pulse.
module tb_mul_err_stats;

   localparam int OW = 32;
   localparam int SW = 8;
   localparam int CW = 16;
   localparam int AW = 64;
   localparam int RW = 2*CW + 3*AW + OW + 1;

   logic          clk, rst_n, start, in_valid, in_ready, busy, done;
   logic [CW-1:0] num_samples, sample_cnt, same_cnt;
   logic [OW-1:0] appr_in, exact_in;
   logic [AW-1:0] err_sum, err_sq_sum, abs_sum;
   logic [OW:0]   max_abs_err;
   logic [1:0]    dbg_state;

   mul_err_stats #(.OUT_WIDTH(OW), .SHIFT_WIDTH(SW), .CNT_WIDTH(CW), .ACC_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready), .appr_in(appr_in), .exact_in(exact_in),
      .busy(busy), .done(done), .sample_cnt(sample_cnt), .same_cnt(same_cnt),
      .err_sum(err_sum), .err_sq_sum(err_sq_sum), .abs_sum(abs_sum),
      .max_abs_err(max_abs_err), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running, required finish");
      $fatal(1);
   end

   int n_pass = 0;
   int n_checks = 0;
   logic [RW-1:0] exp_q[$];

   int cyc = 0;
   int last_acc = 0;
   int start_edge = 0;
   int acc_total = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && in_valid && in_ready) begin
         acc_total <= acc_total + 1;
         last_acc  <= cyc;
      end
      if (rst_n && start && !busy) start_edge <= cyc;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   function automatic logic [RW-1:0] pack(input logic [CW-1:0] c, input logic [CW-1:0] s,
                                          input logic [AW-1:0] su, input logic [AW-1:0] sq,
                                          input logic [AW-1:0] ab, input logic [OW:0] mx);
      return {c, s, su, sq, ab, mx};
   endfunction

   // scoreboard monitor
   logic          done_prev = 1'b0;
   logic [RW-1:0] x;
   always @(negedge clk) begin
      if (done_prev) check("done_single_pulse", {63'd0, done}, 64'd0);
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got done=1 required no pending result");
         end else begin
            x = exp_q.pop_front();
            check("sample_cnt",  {48'd0, sample_cnt},  {48'd0, x[OW+1+3*AW+CW +: CW]});
            check("same_cnt",    {48'd0, same_cnt},    {48'd0, x[OW+1+3*AW +: CW]});
            check("err_sum",     err_sum,              x[OW+1+2*AW +: AW]);
            check("err_sq_sum",  err_sq_sum,           x[OW+1+AW +: AW]);
            check("abs_sum",     abs_sum,              x[OW+1 +: AW]);
            check("max_abs_err", {31'd0, max_abs_err}, {31'd0, x[OW:0]});
            if (x[OW+1+3*AW+CW +: CW] != '0) check("done_latency", 64'(cyc), 64'(last_acc + 4));
            else                              check("done_latency", 64'(cyc), 64'(start_edge + 1));
         end
      end
      done_prev = done;
   end

   // driver tasks (called at a falling edge)
   task automatic do_start(input logic [CW-1:0] n);
      start = 1'b1;
      num_samples = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [OW-1:0] a, input logic [OW-1:0] e);
      int t;
      t = 0;
      in_valid = 1'b1;
      appr_in  = a;
      exact_in = e;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         n_checks++;
         $display("FAIL send_timeout: in_ready=0 for 50 cycles, required 1");
      end else begin
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_results();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"},    {63'd0, in_ready},    64'd0);
      check({tag, "_busy"},        {63'd0, busy},        64'd0);
      check({tag, "_done"},        {63'd0, done},        64'd0);
      check({tag, "_state"},       {62'd0, dbg_state},   64'd0);
      check({tag, "_sample_cnt"},  {48'd0, sample_cnt},  64'd0);
      check({tag, "_same_cnt"},    {48'd0, same_cnt},    64'd0);
      check({tag, "_err_sum"},     err_sum,              64'd0);
      check({tag, "_err_sq_sum"},  err_sq_sum,           64'd0);
      check({tag, "_abs_sum"},     abs_sum,              64'd0);
      check({tag, "_max_abs_err"}, {31'd0, max_abs_err}, 64'd0);
   endtask

   logic          fv [0:8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [OW-1:0] fa [0:8] = '{32'h100, 32'h0, 32'h200, 32'h000, 32'h0, 32'h400,
                               32'h7FFFFF00, 32'h7FFFFF00, 32'h7FFFFF00};
   logic [OW-1:0] fe [0:8] = '{32'h100, 32'h0, 32'h100, 32'h300, 32'h0, 32'h400,
                               32'h80000000, 32'h80000000, 32'h80000000};

   int base;

   initial begin
      rst_n = 1'b0; start = 1'b0; num_samples = '0;
      in_valid = 1'b0; appr_in = '0; exact_in = '0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // basic run with an ignored start in the middle
      do_start(16'd2);
      exp_q.push_back(pack(16'd2, 16'd1, 64'd1, 64'd1, 64'd7, 33'd1));
      send(32'h300, 32'h200);
      start = 1'b1; num_samples = 16'd7;
      @(negedge clk);
      start = 1'b0;
      send(32'h500, 32'h500);
      wait_results();

      // negative / floor, also checks restart clearing
      do_start(16'd1);
      check("restart_sample_cnt", {48'd0, sample_cnt}, 64'd0);
      check("restart_err_sum",    err_sum,              64'd0);
      check("restart_abs_sum",    abs_sum,              64'd0);
      check("restart_max",        {31'd0, max_abs_err}, 64'd0);
      exp_q.push_back(pack(16'd1, 16'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 33'd1));
      send(32'hFFFF_FFFF, 32'h0000_0000);
      wait_results();

      // large error
      do_start(16'd1);
      check("restart2_err_sum", err_sum, 64'd0);
      exp_q.push_back(pack(16'd1, 16'd0, 64'hFF_FFFF, 64'h0000_FFFF_FE00_0001,
                           64'h80_0000, 33'hFF_FFFF));
      send(32'h7FFF_FF00, 32'h8000_0000);
      wait_results();

      // back-to-back accepts
      do_start(16'd3);
      exp_q.push_back(pack(16'd3, 16'd1, 64'd0, 64'd2, 64'd3, 33'd1));
      send(32'h100, 32'h000);
      send(32'h000, 32'h100);
      send(32'h200, 32'h200);
      wait_results();

      // flow control with gaps and surplus samples
      do_start(16'd4);
      base = acc_total;
      exp_q.push_back(pack(16'd4, 16'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd10, 64'd9, 33'd3));
      for (int i = 0; i < 9; i++) begin
         in_valid = fv[i];
         appr_in  = fa[i];
         exact_in = fe[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("flow_in_ready_low", {63'd0, in_ready}, 64'd0);
      check("flow_accepts", 64'(acc_total - base), 64'd4);
      wait_results();

      // zero-sample run
      base = acc_total;
      do_start(16'd0);
      exp_q.push_back(pack(16'd0, 16'd0, 64'd0, 64'd0, 64'd0, 33'd0));
      wait_results();
      check("zero_accepts", 64'(acc_total - base), 64'd0);

      // reset mid-run, then a fresh run
      do_start(16'd3);
      send(32'h900, 32'h100);
      send(32'h100, 32'h900);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_idle("midrun_reset");
      @(negedge clk);
      do_start(16'd1);
      exp_q.push_back(pack(16'd1, 16'd1, 64'd0, 64'd0, 64'd0, 33'd0));
      send(32'h0, 32'h0);
      wait_results();

      repeat (3) @(negedge clk);
      check("pending_results", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
